// File: rtl/rmux_nch_if.sv
// Bus bundle for rmux_nch: master address stream, per-channel address/data
// channels, merged data stream and status.
interface rmux_nch_if #(
    parameter int AW  = 14,
    parameter int DW  = 8,
    parameter int DN  = 8,
    parameter int NCH = 4,
    parameter int IFW = 4,
    parameter int RQD = 4
);
    localparam int CW = $clog2(RQD + 1);

    logic [IFW-1:0]        info;
    logic [AW-1:0]         m_addr;
    logic                  m_addr_first;
    logic                  m_addr_last;
    logic                  m_addr_valid;
    logic                  m_addr_ready;
    logic [NCH*AW-1:0]     s_addr;
    logic [NCH-1:0]        s_addr_first;
    logic [NCH-1:0]        s_addr_last;
    logic [NCH-1:0]        s_addr_valid;
    logic [NCH-1:0]        s_addr_ready;
    logic [NCH*DW*DN-1:0]  m_data;
    logic [NCH-1:0]        m_data_first;
    logic [NCH-1:0]        m_data_last;
    logic [NCH-1:0]        m_data_valid;
    logic [NCH-1:0]        m_data_ready;
    logic [DW*DN-1:0]      s_data;
    logic                  s_data_first;
    logic                  s_data_last;
    logic                  s_data_valid;
    logic                  s_data_ready;
    logic                  sel_err;
    logic [CW-1:0]         outstanding;

    modport slave (
        input  info, m_addr, m_addr_first, m_addr_last, m_addr_valid,
        output m_addr_ready,
        output s_addr, s_addr_first, s_addr_last, s_addr_valid,
        input  s_addr_ready,
        input  m_data, m_data_first, m_data_last, m_data_valid,
        output m_data_ready,
        output s_data, s_data_first, s_data_last, s_data_valid,
        input  s_data_ready,
        output sel_err, outstanding
    );

    modport master (
        output info, m_addr, m_addr_first, m_addr_last, m_addr_valid,
        input  m_addr_ready,
        input  s_addr, s_addr_first, s_addr_last, s_addr_valid,
        output s_addr_ready,
        output m_data, m_data_first, m_data_last, m_data_valid,
        input  m_data_ready,
        input  s_data, s_data_first, s_data_last, s_data_valid,
        output s_data_ready,
        input  sel_err, outstanding
    );
endinterface

// File: rtl/rmux_nch.sv
// N-channel read mux: whole-burst address routing by info, in-order data merge
// driven by a route FIFO of issued channel selects.
//
// state | meaning
// IDLE  | waiting for a first beat; decodes info into a channel select
// BURST | routing the rest of the burst to cur_sel
// DROP  | swallowing a burst whose select was out of range
module rmux_nch #(
    parameter int AW  = 14,
    parameter int DW  = 8,
    parameter int DN  = 8,
    parameter int NCH = 4,
    parameter int IFW = 4,
    parameter int RQD = 4
) (
    input  logic       clk,
    input  logic       rst,
    rmux_nch_if.slave  bus
);
    localparam int SW  = $clog2(NCH);
    localparam int CW  = $clog2(RQD + 1);
    localparam int PW  = (RQD > 1) ? $clog2(RQD) : 1;
    localparam int DBW = DW * DN;

    typedef enum logic [1:0] {IDLE, BURST, DROP} state_t;

    state_t          state;
    logic [SW-1:0]   cur_sel;
    logic [SW-1:0]   fifo_mem [RQD];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            sel_err_q;

    logic [SW-1:0]   sel_in;
    logic            sel_ok;
    logic            full;
    logic            empty;
    logic [SW-1:0]   head;
    logic            route_en;
    logic [SW-1:0]   route_sel;
    logic            addr_ready;
    logic [NCH-1:0]  addr_valid;
    logic            push;
    logic            pop;
    logic            addr_hs;

    logic [DBW-1:0]  dat;
    logic            dat_first;
    logic            dat_last;
    logic            dat_valid;
    logic [NCH-1:0]  dat_ready;

    assign sel_in = bus.info[SW-1:0];
    assign sel_ok = {1'b0, sel_in} < (SW+1)'(NCH);
    assign full   = (count == CW'(RQD));
    assign empty  = (count == '0);
    assign head   = fifo_mem[rd_ptr];

    always_comb begin
        route_en   = 1'b0;
        route_sel  = cur_sel;
        addr_ready = 1'b0;
        addr_valid = '0;
        case (state)
            IDLE: begin
                if (bus.m_addr_valid) begin
                    if (!bus.m_addr_first || !sel_ok) begin
                        addr_ready = 1'b1;
                    end else if (!full) begin
                        route_en  = 1'b1;
                        route_sel = sel_in;
                    end
                end
            end
            BURST:   route_en   = 1'b1;
            DROP:    addr_ready = 1'b1;
            default: ;
        endcase
        if (route_en) begin
            for (int k = 0; k < NCH; k++) begin
                if (route_sel == SW'(k)) begin
                    addr_valid[k] = bus.m_addr_valid;
                    addr_ready    = bus.s_addr_ready[k];
                end
            end
        end
        if (rst) begin
            addr_ready = 1'b0;
            addr_valid = '0;
        end
    end

    assign addr_hs = bus.m_addr_valid && addr_ready;
    assign push    = (state == IDLE) && route_en && addr_hs && !rst;

    always_comb begin
        dat       = '0;
        dat_first = 1'b0;
        dat_last  = 1'b0;
        dat_valid = 1'b0;
        dat_ready = '0;
        if (!empty && !rst) begin
            for (int k = 0; k < NCH; k++) begin
                if (head == SW'(k)) begin
                    dat          = bus.m_data[k*DBW +: DBW];
                    dat_first    = bus.m_data_first[k];
                    dat_last     = bus.m_data_last[k];
                    dat_valid    = bus.m_data_valid[k];
                    dat_ready[k] = bus.s_data_ready;
                end
            end
        end
    end

    assign pop = dat_valid && bus.s_data_ready && dat_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_sel   <= '0;
            sel_err_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            sel_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_addr_valid && bus.m_addr_first) begin
                        if (!sel_ok) begin
                            sel_err_q <= 1'b1;
                            if (!bus.m_addr_last) state <= DROP;
                        end else if (push) begin
                            cur_sel <= sel_in;
                            if (!bus.m_addr_last) state <= BURST;
                        end
                    end
                end
                BURST: if (addr_hs && bus.m_addr_last) state <= IDLE;
                DROP:  if (bus.m_addr_valid && bus.m_addr_last) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (push) begin
                fifo_mem[wr_ptr] <= sel_in;
                wr_ptr <= (wr_ptr == PW'(RQD-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(RQD-1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Address/first/last are broadcast; only the routed slot's valid asserts.
    assign bus.m_addr_ready = addr_ready;
    assign bus.s_addr       = {NCH{bus.m_addr}};
    assign bus.s_addr_first = {NCH{bus.m_addr_first}};
    assign bus.s_addr_last  = {NCH{bus.m_addr_last}};
    assign bus.s_addr_valid = addr_valid;
    assign bus.m_data_ready = dat_ready;
    assign bus.s_data       = dat;
    assign bus.s_data_first = dat_first;
    assign bus.s_data_last  = dat_last;
    assign bus.s_data_valid = dat_valid;
    assign bus.sel_err      = sel_err_q;
    assign bus.outstanding  = count;
endmodule

// File: tb/tb_rmux_nch.sv
// Directed bench for rmux_nch: a 4-channel instance for routing/merge/FIFO
// behaviour and a 3-channel instance for out-of-range select handling.
module tb_rmux_nch;
    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int DN  = 8;
    localparam int IFW = 4;
    localparam int RQD = 4;
    localparam int DBW = DW * DN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rmux_nch_if #(.AW(AW), .DW(DW), .DN(DN), .NCH(4), .IFW(IFW), .RQD(RQD)) bus4 ();
    rmux_nch_if #(.AW(AW), .DW(DW), .DN(DN), .NCH(3), .IFW(IFW), .RQD(RQD)) bus3 ();

    rmux_nch #(.AW(AW), .DW(DW), .DN(DN), .NCH(4), .IFW(IFW), .RQD(RQD)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    rmux_nch #(.AW(AW), .DW(DW), .DN(DN), .NCH(3), .IFW(IFW), .RQD(RQD)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus4.info = '0; bus4.m_addr = '0; bus4.m_addr_first = 0; bus4.m_addr_last = 0;
        bus4.m_addr_valid = 0; bus4.s_addr_ready = '0; bus4.m_data = '0;
        bus4.m_data_first = '0; bus4.m_data_last = '0; bus4.m_data_valid = '0;
        bus4.s_data_ready = 0;
        bus3.info = '0; bus3.m_addr = '0; bus3.m_addr_first = 0; bus3.m_addr_last = 0;
        bus3.m_addr_valid = 0; bus3.s_addr_ready = '0; bus3.m_data = '0;
        bus3.m_data_first = '0; bus3.m_data_last = '0; bus3.m_data_valid = '0;
        bus3.s_data_ready = 0;
    endtask

    task automatic addr4(input int inf, input int a, input bit f, input bit l);
        bus4.info = IFW'(inf); bus4.m_addr = AW'(a);
        bus4.m_addr_first = f; bus4.m_addr_last = l; bus4.m_addr_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr4(2, 5, 1, 1);
        bus4.s_addr_ready = 4'hF;
        tick();
        tick();
        checks++;
        if (bus4.m_addr_ready !== 1'b0) begin
            failures++; $display("FAIL reset_m_addr_ready got %0b want 0", bus4.m_addr_ready);
        end
        checks++;
        if (bus4.s_addr_valid !== 4'b0000) begin
            failures++; $display("FAIL reset_s_addr_valid got %b want 0000", bus4.s_addr_valid);
        end
        checks++;
        if (bus4.outstanding !== 3'd0 || bus4.sel_err !== 1'b0) begin
            failures++; $display("FAIL reset_status got outstanding=%0d sel_err=%0b want 0/0",
                                 bus4.outstanding, bus4.sel_err);
        end
        checks++;
        if (bus4.m_data_ready !== 4'b0000 || bus4.s_data_valid !== 1'b0) begin
            failures++; $display("FAIL reset_data got m_data_ready=%b s_data_valid=%0b want 0000/0",
                                 bus4.m_data_ready, bus4.s_data_valid);
        end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        logic [DBW-1:0] vals [4];
        vals[0] = 64'd1; vals[1] = 64'd3; vals[2] = 64'd5; vals[3] = 64'd7;
        bus4.s_addr_ready = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            addr4((i == 0) ? 2 : 0, 100 + i, i == 0, i == 3);
            #1;
            checks++;
            if (bus4.s_addr_valid !== 4'b0100 || bus4.m_addr_ready !== 1'b1) begin
                failures++; $display("FAIL burst_addr_route beat %0d got valid=%b ready=%0b want 0100/1",
                                     i, bus4.s_addr_valid, bus4.m_addr_ready);
            end
            checks++;
            if (bus4.s_addr[2*AW +: AW] !== AW'(100 + i)) begin
                failures++; $display("FAIL burst_addr_value beat %0d got %0d want %0d",
                                     i, bus4.s_addr[2*AW +: AW], 100 + i);
            end
            tick();
        end
        bus4.m_addr_valid = 1'b0;
        #1;
        checks++;
        if (bus4.outstanding !== 3'd1 || bus4.s_addr_valid !== 4'b0000) begin
            failures++; $display("FAIL burst_outstanding got %0d valid=%b want 1/0000",
                                 bus4.outstanding, bus4.s_addr_valid);
        end
        bus4.s_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus4.m_data[2*DBW +: DBW] = vals[i];
            bus4.m_data_valid = 4'b0100;
            bus4.m_data_first = (i == 0) ? 4'b0100 : 4'b0000;
            bus4.m_data_last  = (i == 3) ? 4'b0100 : 4'b0000;
            #1;
            checks++;
            if (bus4.s_data !== vals[i] || bus4.s_data_valid !== 1'b1 ||
                bus4.s_data_last !== (i == 3) || bus4.m_data_ready !== 4'b0100) begin
                failures++; $display("FAIL burst_data beat %0d got data=%0d valid=%0b last=%0b rdy=%b want %0d/1/%0b/0100",
                                     i, bus4.s_data, bus4.s_data_valid, bus4.s_data_last,
                                     bus4.m_data_ready, vals[i], i == 3);
            end
            tick();
        end
        clear_inputs();
        #1;
        checks++;
        if (bus4.outstanding !== 3'd0) begin
            failures++; $display("FAIL burst_drain got outstanding=%0d want 0", bus4.outstanding);
        end
    endtask

    task automatic test_order();
        bus4.s_addr_ready = 4'hF;
        addr4(1, 10, 1, 1);
        tick();
        addr4(3, 11, 1, 1);
        tick();
        bus4.m_addr_valid = 1'b0;
        bus4.s_data_ready = 1'b1;
        bus4.m_data[3*DBW +: DBW] = 64'h33;
        bus4.m_data_valid = 4'b1000; bus4.m_data_first = 4'b1000; bus4.m_data_last = 4'b1000;
        #1;
        checks++;
        if (bus4.outstanding !== 3'd2 || bus4.m_data_ready !== 4'b0010 || bus4.s_data_valid !== 1'b0) begin
            failures++; $display("FAIL order_stall got out=%0d rdy=%b valid=%0b want 2/0010/0",
                                 bus4.outstanding, bus4.m_data_ready, bus4.s_data_valid);
        end
        tick();
        checks++;
        if (bus4.m_data_ready[3] !== 1'b0 || bus4.outstanding !== 3'd2) begin
            failures++; $display("FAIL order_stall_hold got rdy3=%0b out=%0d want 0/2",
                                 bus4.m_data_ready[3], bus4.outstanding);
        end
        bus4.m_data[1*DBW +: DBW] = 64'h11;
        bus4.m_data_valid = 4'b1010; bus4.m_data_first = 4'b1010; bus4.m_data_last = 4'b1010;
        #1;
        checks++;
        if (bus4.s_data !== 64'h11 || bus4.s_data_valid !== 1'b1 || bus4.m_data_ready !== 4'b0010) begin
            failures++; $display("FAIL order_first got data=%0h valid=%0b rdy=%b want 11/1/0010",
                                 bus4.s_data, bus4.s_data_valid, bus4.m_data_ready);
        end
        tick();
        bus4.m_data_valid = 4'b1000;
        #1;
        checks++;
        if (bus4.s_data !== 64'h33 || bus4.s_data_valid !== 1'b1 || bus4.m_data_ready !== 4'b1000) begin
            failures++; $display("FAIL order_second got data=%0h valid=%0b rdy=%b want 33/1/1000",
                                 bus4.s_data, bus4.s_data_valid, bus4.m_data_ready);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus4.outstanding !== 3'd0) begin
            failures++; $display("FAIL order_drain got outstanding=%0d want 0", bus4.outstanding);
        end
    endtask

    task automatic test_full();
        logic [DBW-1:0] exp_seq [4];
        exp_seq[0] = 64'hA1; exp_seq[1] = 64'hA2; exp_seq[2] = 64'hA3; exp_seq[3] = 64'hA0;
        bus4.s_addr_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            addr4(k, 20 + k, 1, 1);
            tick();
        end
        addr4(0, 30, 1, 1);
        #1;
        checks++;
        if (bus4.outstanding !== 3'd4 || bus4.m_addr_ready !== 1'b0 || bus4.s_addr_valid !== 4'b0000) begin
            failures++; $display("FAIL full_block got out=%0d ready=%0b valid=%b want 4/0/0000",
                                 bus4.outstanding, bus4.m_addr_ready, bus4.s_addr_valid);
        end
        bus4.m_data[0 +: DBW] = 64'hA0;
        bus4.m_data_valid = 4'b0001; bus4.m_data_first = 4'b0001; bus4.m_data_last = 4'b0001;
        bus4.s_data_ready = 1'b1;
        #1;
        checks++;
        if (bus4.m_addr_ready !== 1'b0 || bus4.s_data_valid !== 1'b1) begin
            failures++; $display("FAIL full_pop_same_cycle got ready=%0b dvalid=%0b want 0/1",
                                 bus4.m_addr_ready, bus4.s_data_valid);
        end
        tick();
        bus4.m_data_valid = 4'b0000;
        #1;
        checks++;
        if (bus4.outstanding !== 3'd3 || bus4.m_addr_ready !== 1'b1 || bus4.s_addr_valid !== 4'b0001) begin
            failures++; $display("FAIL full_accept_fifth got out=%0d ready=%0b valid=%b want 3/1/0001",
                                 bus4.outstanding, bus4.m_addr_ready, bus4.s_addr_valid);
        end
        tick();
        bus4.m_addr_valid = 1'b0;
        for (int k = 0; k < 4; k++) bus4.m_data[k*DBW +: DBW] = DBW'(8'hA0 + k);
        bus4.m_data_valid = 4'hF; bus4.m_data_first = 4'hF; bus4.m_data_last = 4'hF;
        #1;
        checks++;
        if (bus4.outstanding !== 3'd4) begin
            failures++; $display("FAIL full_refill got outstanding=%0d want 4", bus4.outstanding);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus4.s_data !== exp_seq[i] || bus4.s_data_valid !== 1'b1) begin
                failures++; $display("FAIL full_drain_order beat %0d got %0h valid=%0b want %0h/1",
                                     i, bus4.s_data, bus4.s_data_valid, exp_seq[i]);
            end
            tick();
        end
        clear_inputs();
        #1;
        checks++;
        if (bus4.outstanding !== 3'd0 || bus4.s_data_valid !== 1'b0) begin
            failures++; $display("FAIL full_empty got out=%0d valid=%0b want 0/0",
                                 bus4.outstanding, bus4.s_data_valid);
        end
    endtask

    task automatic test_backpressure();
        int got_beats = 0;
        bus4.s_addr_ready = 4'b0010;
        addr4(1, 200, 1, 0);
        #1;
        if (bus4.m_addr_ready === 1'b1) got_beats++;
        tick();
        addr4(0, 201, 0, 0);
        bus4.s_addr_ready = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus4.m_addr_ready !== 1'b0 || bus4.s_addr_valid !== 4'b0010 ||
                bus4.s_addr[1*AW +: AW] !== AW'(201)) begin
                failures++; $display("FAIL bp_hold cycle %0d got ready=%0b valid=%b addr=%0d want 0/0010/201",
                                     i, bus4.m_addr_ready, bus4.s_addr_valid, bus4.s_addr[1*AW +: AW]);
            end
            tick();
        end
        bus4.s_addr_ready = 4'b0010;
        #1;
        checks++;
        if (bus4.m_addr_ready !== 1'b1 || bus4.s_addr[1*AW +: AW] !== AW'(201)) begin
            failures++; $display("FAIL bp_resume got ready=%0b addr=%0d want 1/201",
                                 bus4.m_addr_ready, bus4.s_addr[1*AW +: AW]);
        end
        if (bus4.m_addr_ready === 1'b1) got_beats++;
        tick();
        addr4(0, 202, 0, 1);
        #1;
        if (bus4.m_addr_ready === 1'b1 && bus4.s_addr_valid === 4'b0010) got_beats++;
        tick();
        bus4.m_addr_valid = 1'b0;
        #1;
        checks++;
        if (got_beats !== 3 || bus4.outstanding !== 3'd1) begin
            failures++; $display("FAIL bp_beats got beats=%0d out=%0d want 3/1", got_beats, bus4.outstanding);
        end
        bus4.s_data_ready = 1'b1;
        bus4.m_data_valid = 4'b0010; bus4.m_data_first = 4'b0010; bus4.m_data_last = 4'b0010;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus4.outstanding !== 3'd0) begin
            failures++; $display("FAIL bp_drain got outstanding=%0d want 0", bus4.outstanding);
        end
    endtask

    task automatic test_sel_err();
        bus3.s_addr_ready = 3'b111;
        bus3.info = 4'd3; bus3.m_addr = 14'd300;
        bus3.m_addr_first = 1'b1; bus3.m_addr_last = 1'b0; bus3.m_addr_valid = 1'b1;
        #1;
        checks++;
        if (bus3.m_addr_ready !== 1'b1 || bus3.s_addr_valid !== 3'b000 || bus3.sel_err !== 1'b0) begin
            failures++; $display("FAIL selerr_accept got ready=%0b valid=%b err=%0b want 1/000/0",
                                 bus3.m_addr_ready, bus3.s_addr_valid, bus3.sel_err);
        end
        tick();
        bus3.info = 4'd1; bus3.m_addr = 14'd301;
        bus3.m_addr_first = 1'b0; bus3.m_addr_last = 1'b1;
        #1;
        checks++;
        if (bus3.sel_err !== 1'b1 || bus3.m_addr_ready !== 1'b1 || bus3.s_addr_valid !== 3'b000) begin
            failures++; $display("FAIL selerr_pulse got err=%0b ready=%0b valid=%b want 1/1/000",
                                 bus3.sel_err, bus3.m_addr_ready, bus3.s_addr_valid);
        end
        tick();
        bus3.m_addr_valid = 1'b0;
        #1;
        checks++;
        if (bus3.sel_err !== 1'b0 || bus3.outstanding !== 3'd0) begin
            failures++; $display("FAIL selerr_end got err=%0b out=%0d want 0/0",
                                 bus3.sel_err, bus3.outstanding);
        end
        bus3.info = 4'd2; bus3.m_addr = 14'd302;
        bus3.m_addr_first = 1'b1; bus3.m_addr_last = 1'b1; bus3.m_addr_valid = 1'b1;
        #1;
        checks++;
        if (bus3.s_addr_valid !== 3'b100 || bus3.m_addr_ready !== 1'b1) begin
            failures++; $display("FAIL selerr_recover got valid=%b ready=%0b want 100/1",
                                 bus3.s_addr_valid, bus3.m_addr_ready);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus3.outstanding !== 3'd1) begin
            failures++; $display("FAIL selerr_push got outstanding=%0d want 1", bus3.outstanding);
        end
    endtask

    task automatic test_reset_mid();
        bus4.s_addr_ready = 4'hF;
        addr4(0, 40, 1, 1);
        tick();
        addr4(2, 41, 1, 0);
        tick();
        addr4(0, 42, 0, 0);
        #1;
        checks++;
        if (bus4.outstanding !== 3'd2 || bus4.s_addr_valid !== 4'b0100) begin
            failures++; $display("FAIL rstmid_pre got out=%0d valid=%b want 2/0100",
                                 bus4.outstanding, bus4.s_addr_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus4.m_addr_ready !== 1'b0 || bus4.s_addr_valid !== 4'b0000) begin
            failures++; $display("FAIL rstmid_during got ready=%0b valid=%b want 0/0000",
                                 bus4.m_addr_ready, bus4.s_addr_valid);
        end
        tick();
        rst = 1'b0;
        bus4.m_addr_valid = 1'b0;
        #1;
        checks++;
        if (bus4.outstanding !== 3'd0 || bus4.s_addr_valid !== 4'b0000 || bus4.s_data_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_after got out=%0d valid=%b dvalid=%0b want 0/0000/0",
                                 bus4.outstanding, bus4.s_addr_valid, bus4.s_data_valid);
        end
        addr4(0, 43, 0, 1);
        #1;
        checks++;
        if (bus4.m_addr_ready !== 1'b1 || bus4.s_addr_valid !== 4'b0000) begin
            failures++; $display("FAIL rstmid_idle_discard got ready=%0b valid=%b want 1/0000",
                                 bus4.m_addr_ready, bus4.s_addr_valid);
        end
        tick();
        addr4(3, 44, 1, 1);
        #1;
        checks++;
        if (bus4.s_addr_valid !== 4'b1000 || bus4.s_addr[3*AW +: AW] !== AW'(44)) begin
            failures++; $display("FAIL rstmid_new_route got valid=%b addr=%0d want 1000/44",
                                 bus4.s_addr_valid, bus4.s_addr[3*AW +: AW]);
        end
        tick();
        bus4.m_addr_valid = 1'b0;
        #1;
        checks++;
        if (bus4.outstanding !== 3'd1) begin
            failures++; $display("FAIL rstmid_new_push got outstanding=%0d want 1", bus4.outstanding);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_burst();
        test_order();
        test_full();
        test_backpressure();
        test_sel_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
